// File: rtl/led_trail_pwm_if.sv
`default_nettype none
// ============================================================================
//  Module      : led_trail_pwm_if
//  Description : LED pattern bundle between the walker and the trail PWM
//                stage. The master (walker side) drives the requested
//                pattern and observes the PWM pin drive; the slave (PWM
//                stage) consumes the pattern and produces the pin drive.
//  Revision    : 1.0 - initial release
// ============================================================================
interface led_trail_pwm_if #(
    parameter int NLEDS = 8
);
    logic [NLEDS-1:0] i_led;
    logic [NLEDS-1:0] o_led;

    modport master (output i_led, input o_led);
    modport slave  (input i_led, output o_led);
endinterface
`default_nettype wire

// File: rtl/led_trail_pwm.sv
`default_nettype none
// ============================================================================
//  Module      : led_trail_pwm
//  Description : Per-LED PWM display stage with decaying brightness. A lit
//                request loads full brightness; released LEDs fade by
//                DECAY_STEP every DECAY_DIV clocks, leaving a comet tail.
//                Optional macro LED_TRAIL_GAMMA_EN squares the brightness
//                into the duty value for a perceptually linear fade.
//  Revision    : 1.0 - initial release
// ============================================================================
module led_trail_pwm #(
    parameter int NLEDS      = 8,
    parameter int PWM_BITS   = 8,
    parameter int DECAY_DIV  = 187_500,
    parameter int DECAY_STEP = 16
) (
    input  wire logic         i_clk,
    input  wire logic         i_reset,
    led_trail_pwm_if.slave    led_bus
);

    localparam logic [PWM_BITS-1:0] MAX          = '1;
    localparam int                  DW           = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;
    localparam logic [DW-1:0]       DECAY_RELOAD = DW'(DECAY_DIV - 1);
    localparam logic [31:0]         STEP32       = 32'(DECAY_STEP);
    localparam logic [PWM_BITS-1:0] STEP         = PWM_BITS'(DECAY_STEP);

    logic [PWM_BITS-1:0] pwm_cnt;
    logic [DW-1:0]       decay_cnt;
    logic                decay_stb;
    logic [NLEDS-1:0]    led_nxt;

    // Free-running PWM phase counter, wraps naturally at MAX.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
        end
    end

    // Decay prescaler: one-clock strobe registered on the cycle after reaching 0.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            decay_cnt <= DECAY_RELOAD;
            decay_stb <= 1'b0;
        end else if (decay_cnt == '0) begin
            decay_cnt <= DECAY_RELOAD;
            decay_stb <= 1'b1;
        end else begin
            decay_cnt <= decay_cnt - 1'b1;
            decay_stb <= 1'b0;
        end
    end

    generate
        for (genvar k = 0; k < NLEDS; k++) begin : g_led
            logic [PWM_BITS-1:0] bright;
            logic [PWM_BITS-1:0] duty;

            // Brightness: a request reloads full scale (beating a coincident
            // strobe); otherwise fade with a saturating, compare-first subtract.
            always_ff @(posedge i_clk) begin
                if (i_reset) begin
                    bright <= '0;
                end else if (led_bus.i_led[k]) begin
                    bright <= MAX;
                end else if (decay_stb) begin
                    if (32'(bright) > STEP32) begin
                        bright <= bright - STEP;
                    end else begin
                        bright <= '0;
                    end
                end
            end

`ifdef LED_TRAIL_GAMMA_EN
            logic [2*PWM_BITS-1:0] sq;
            assign sq   = {{PWM_BITS{1'b0}}, bright} * {{PWM_BITS{1'b0}}, bright};
            assign duty = sq[2*PWM_BITS-1:PWM_BITS];
`else
            assign duty = bright;
`endif

            // Full scale is forced on so the lit LED has no PWM gap.
            assign led_nxt[k] = (bright == MAX) ? 1'b1 : (duty > pwm_cnt);
        end
    endgenerate

    // Registered pin drive.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            led_bus.o_led <= '0;
        end else begin
            led_bus.o_led <= led_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_led_trail_pwm.sv
`default_nettype none
// ============================================================================
//  Module      : tb_led_trail_pwm
//  Description : Self-checking bench for led_trail_pwm with PWM_BITS=4,
//                DECAY_DIV=4, DECAY_STEP=3. A reference model tracks each
//                LED's brightness as a number and derives PWM phase and
//                decay instants from the count of edges since reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_led_trail_pwm;

    localparam int NL   = 8;
    localparam int PB   = 4;
    localparam int DD   = 4;
    localparam int DS   = 3;
    localparam int MAXV = (1 << PB) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    led_trail_pwm_if #(.NLEDS(NL)) bus ();

    led_trail_pwm #(
        .NLEDS      (NL),
        .PWM_BITS   (PB),
        .DECAY_DIV  (DD),
        .DECAY_STEP (DS)
    ) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .led_bus (bus)
    );

    // Reference model state
    int            bm [NL];
    int            e;
    logic [NL-1:0] exp_led;
    int            checks;
    int            errors;

    function automatic int duty_of(input int b);
`ifdef LED_TRAIL_GAMMA_EN
        return (b * b) >> PB;
`else
        return b;
`endif
    endfunction

    // Drive one clock of stimulus and advance the model across that edge.
    task automatic tick(input logic [NL-1:0] pat, input logic r);
        bit stb;
        @(negedge clk);
        bus.i_led = pat;
        rst       = r;
        @(posedge clk);
        if (r) begin
            e       = 0;
            exp_led = '0;
            for (int k = 0; k < NL; k++) bm[k] = 0;
        end else begin
            stb = (e > 0) && (e % DD == 0);
            for (int k = 0; k < NL; k++) begin
                exp_led[k] = (bm[k] == MAXV) ? 1'b1 : (duty_of(bm[k]) > (e % (1 << PB)));
                if (pat[k])       bm[k] = MAXV;
                else if (stb)     bm[k] = (bm[k] > DS) ? bm[k] - DS : 0;
            end
            e++;
        end
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            tick(8'hFF, 1'b1);
            checks++;
            if (bus.o_led !== 8'h00) begin
                errors++;
                $display("FAIL reset_hold cyc%0d: o_led=%h expected 00", i, bus.o_led);
            end
        end
        tick(8'hFF, 1'b0);
        checks++;
        if (bus.o_led !== 8'h00) begin
            errors++;
            $display("FAIL reset_latency: o_led=%h expected 00", bus.o_led);
        end
        for (int i = 0; i < 20; i++) begin
            tick(8'hFF, 1'b0);
            checks++;
            if (bus.o_led !== 8'hFF || bus.o_led !== exp_led) begin
                errors++;
                $display("FAIL reset_release cyc%0d: o_led=%h expected FF", i, bus.o_led);
            end
        end
    endtask

    task automatic test_steady();
        tick(8'h00, 1'b1);
        tick(8'h00, 1'b1);
        for (int i = 0; i < 65; i++) begin
            tick(8'h01, 1'b0);
            checks++;
            if (bus.o_led !== exp_led || (i >= 1 && bus.o_led !== 8'h01)) begin
                errors++;
                $display("FAIL steady cyc%0d: o_led=%h expected %h", i, bus.o_led, exp_led);
            end
        end
    endtask

    task automatic test_decay();
        tick(8'h00, 1'b1);
        tick(8'h00, 1'b1);
        tick(8'h01, 1'b0);
        for (int i = 0; i < 100; i++) begin
            tick(8'h00, 1'b0);
            checks++;
            if (bus.o_led !== exp_led || (i >= 40 && bus.o_led !== 8'h00)) begin
                errors++;
                $display("FAIL decay cyc%0d: o_led=%h expected %h", i, bus.o_led, exp_led);
            end
        end
    endtask

    task automatic test_simultaneous();
        bit found = 1'b0;
        tick(8'h00, 1'b1);
        tick(8'h01, 1'b0);
        for (int i = 0; i < 100 && !found; i++) begin
            if (bm[0] == 6 && e > 0 && e % DD == 0) found = 1'b1;
            else tick(8'h00, 1'b0);
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL simul_setup: bright 6 at strobe not reached, found=%0d expected 1", found);
        end
        tick(8'h01, 1'b0);
        for (int i = 0; i < 6; i++) begin
            tick(8'h00, 1'b0);
            checks++;
            if (bus.o_led !== exp_led || (i < 3 && bus.o_led[0] !== 1'b1)) begin
                errors++;
                $display("FAIL simul cyc%0d: o_led=%h expected %h", i, bus.o_led, exp_led);
            end
        end
    endtask

    task automatic test_walker();
        logic [NL-1:0] pat;
        tick(8'h00, 1'b1);
        for (int s = 0; s < 4; s++) begin
            pat = NL'(1) << s;
            for (int j = 0; j < 8; j++) begin
                tick(pat, 1'b0);
                checks++;
                if (bus.o_led !== exp_led || (j >= 1 && (bus.o_led & pat) !== pat)) begin
                    errors++;
                    $display("FAIL walker s%0d j%0d: o_led=%h expected %h", s, j, bus.o_led, exp_led);
                end
            end
        end
        tick(8'h08, 1'b1);
        checks++;
        if (bus.o_led !== 8'h00) begin
            errors++;
            $display("FAIL walker_reset: o_led=%h expected 00", bus.o_led);
        end
    endtask

    task automatic test_random();
        logic [NL-1:0] pat;
        logic          r;
        tick(8'h00, 1'b1);
        for (int i = 0; i < 1500; i++) begin
            case ($urandom_range(0, 3))
                0:       pat = NL'($urandom);
                1:       pat = NL'(1) << $urandom_range(0, NL - 1);
                default: pat = '0;
            endcase
            r = ($urandom_range(0, 63) == 0);
            tick(pat, r);
            checks++;
            if (bus.o_led !== exp_led) begin
                errors++;
                $display("FAIL random cyc%0d: o_led=%h expected %h", i, bus.o_led, exp_led);
            end
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        e         = 0;
        exp_led   = '0;
        bus.i_led = '0;
        for (int k = 0; k < NL; k++) bm[k] = 0;
        test_reset();
        test_steady();
        test_decay();
        test_simultaneous();
        test_walker();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/led_trail_pwm.md
# led_trail_pwm

Downstream display stage for the LED walker. Takes the walker's one-hot (or any) 8-bit LED pattern and drives the physical LEDs through per-LED PWM with a decaying brightness. The lit LED shows at full brightness, and LEDs that have just turned off fade out, giving a visible "comet tail" behind the walking light. It sits between the walker's `o_led` register and the board LED pins.

## Interface
- `NLEDS`, default 8: number of LED channels.
- `PWM_BITS`, default 8: width of the PWM counter and of each brightness value. MAX = 2^PWM_BITS-1.
- `DECAY_DIV`, default 187_500: clocks between decay steps. Must be ≥1. At 12 MHz this gives 64 steps/s.
- `DECAY_STEP`, default 16: brightness subtracted per decay step. Must be ≥1.
- `i_clk  input  1`: the single clock. All state updates on its rising edge.
- `i_reset  input  1`: reset, synchronous and active-high.
- `i_led  input  NLEDS`: requested pattern. Bit high means that LED is lit at full brightness.
- `o_led  output  NLEDS`: registered PWM drive to the LED pins.

## Operation
- **PWM counter `pwm_cnt`** (PWM_BITS):
  - Increments every clock and wraps MAX→0.
  - The PWM period is 2^PWM_BITS clocks.
- **Decay timer** (≥ clog2(DECAY_DIV) bits):
  - Counts down from DECAY_DIV-1.
  - At 0 it reloads DECAY_DIV-1 and asserts `decay_stb` for exactly one clock (registered, the cycle after the counter reaches 0).
  - With DECAY_DIV=1, `decay_stb` is high every cycle.
- **Brightness registers `bright[k]`** (PWM_BITS each), updated per LED with this priority:
  1. `i_reset`: 0.
  2. `i_led[k]`=1: load MAX. Loading wins over a coincident `decay_stb`.
  3. `decay_stb`: if bright[k] > DECAY_STEP, subtract DECAY_STEP; otherwise set to 0 (saturating, never wraps).
  4. Otherwise: hold.
- **Duty `duty[k]`** is `bright[k]`, or gamma-corrected per Configuration.
- **Output** `o_led[k]` is registered each clock:
  - `bright[k]`==MAX: forced to 1 (true 100% duty).
  - Otherwise: `duty[k] > pwm_cnt`.
  - Consequence: bright=0 gives a constant 0, and bright=b<MAX gives exactly b high cycles per PWM period (without gamma).
- No state machine beyond the counters. Each LED channel is independent and identical (generate loop).
- Widths:
  - The decay subtraction is done in PWM_BITS with a compare-before-subtract, so there is no underflow.
  - The gamma product is 2·PWM_BITS wide before shifting.

## Timing
- Reset values:
  - `o_led`=0
  - all `bright`=0
  - `pwm_cnt`=0
  - decay counter = DECAY_DIV-1
  - `decay_stb`=0
- Reset held any number of cycles forces all of the above, regardless of `i_led`. Reset mid-fade drops every LED to 0 immediately, with no tail.
- Latency is 2 clocks from `i_led[k]` rising (sampled at edge n) to `o_led[k]`=1:
  - `bright` is MAX after edge n.
  - `o_led` is high after edge n+1.
- Turn-off: `o_led[k]` stays high until the first `decay_stb` after `i_led[k]` falls. From then on it follows the PWM of the decreasing brightness.
- Full fade-out takes ceil(MAX/DECAY_STEP) decay steps.
- `i_led` needs no handshake. It is sampled every clock, and a 1-cycle pulse is sufficient to load MAX.
- The first `decay_stb` after reset release occurs DECAY_DIV cycles after release.

## Configuration
- **`LED_TRAIL_GAMMA_EN` defined:**
  - `duty[k] = (bright[k]*bright[k]) >> PWM_BITS`, computed combinationally from `bright`.
  - Latency is unchanged. The MAX force-on still applies.
  - Gives a perceptually linear fade.
- **Not defined:** `duty[k] = bright[k]`, and no multiplier is synthesized.

## Test plan
Benches use PWM_BITS=4, DECAY_DIV=4, DECAY_STEP=3 unless stated.

- **Reset priority:** `i_led`=8'hFF while `i_reset`=1 for 3 cycles → `o_led`=0 throughout. After release, `o_led`=8'hFF two clocks later and stays 8'hFF.
- **Steady on:** `i_led`=8'h01 held 64 cycles → `o_led`=8'h01 every cycle after the 2-clock latency, with no PWM gaps.
- **Decay sequence:** `i_led`[0] pulsed for one cycle, then 0 →
  - `bright[0]` goes 15→12→9→6→3→0 on successive `decay_stb`.
  - High cycles of `o_led[0]` per 16-cycle window match the current brightness.
  - `o_led[0]`=0 constantly after reaching 0. Decay never goes below 0.
- **Simultaneous load/decay:** `i_led[0]`=1 on the same cycle as `decay_stb` with bright=6 → bright=15 and `o_led[0]` forced high.
- **Walker pattern:** drive 8'h01,8'h02,8'h04,8'h08, each for 8 cycles → current LED constantly on, trailing LEDs show strictly decreasing duty, and reset mid-walk clears all outputs next cycle.
- **Gamma:** with `LED_TRAIL_GAMMA_EN`, bright=8 → 4 high cycles per 16-cycle period. Without the macro → 8 high cycles.
